comparador_serie_nb: RTL



---
 rtl/comparador_serie_nb_pkg.sv | 25 ++
 rtl/comparador_serie_nb_if.sv | 32 +++
 rtl/comparador_serie_nb_chunk.sv | 15 +
 rtl/comparador_serie_nb.sv | 113 +++++++++++
 4 files changed

// File: rtl/comparador_serie_nb_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
// Result encoding is one-hot {eq, lt, gt}; all-zero means no comparison since reset.
package comparador_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  typedef logic [2:0] res_t;
  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_EQ   = 3'b100;
  localparam res_t RES_LT   = 3'b010;
  localparam res_t RES_GT   = 3'b001;

  function automatic int nchunk(input int w, input int chunk);
    return w / chunk;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparador_serie_nb_if.sv
// Start/busy/done handshake and operand bus of the serial comparator.
// The master drives the request side; the slave (comparator) drives the results.
interface comparador_serie_nb_if #(
  parameter int W     = 8,
  parameter int CHUNK = 2
);
  import comparador_pkg::*;

  localparam int CW = cnt_width(nchunk(W, CHUNK));

  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_mode;
  logic          busy;
  logic          done;
  logic          eq;
  logic          lt;
  logic          gt;
  logic [CW-1:0] cycles;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, eq, lt, gt, cycles
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, eq, lt, gt, cycles
  );

endinterface

// File: rtl/comparador_serie_nb_chunk.sv
// Combinational CHUNK-bit compare cell: equality plus unsigned greater-than.
// Generalises the old 2-bit XNOR equality cell to any width.
module comparador_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_eq,
  output logic             o_gt
);

  assign o_eq = &(~(i_a ^ i_b));
  assign o_gt = (i_a > i_b);

endmodule

// File: rtl/comparador_serie_nb.sv
// Serial W-bit comparator, CHUNK bits per cycle MSB first; busy for 1..NCHUNK cycles.
// start is accepted only when idle; results are registered and held until the next done.
module comparador_serie_nb
  import comparador_pkg::*;
#(
  parameter int W          = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  comparador_serie_nb_if.slave bus
);

  localparam int NCHUNK = nchunk(W, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam int IW     = idx_width(NCHUNK);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_diff;
  logic            r_gt_found;
  logic            r_busy;
  logic            r_done;
  res_t            r_res;
  logic [CW-1:0]   r_cycles;

  logic [W-1:0]     w_flip;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_chunk_eq;
  logic             w_chunk_gt;
  logic             w_diff_next;
  logic             w_gt_next;
  logic             w_end;

  // Flipping the sign bit maps two's complement onto offset binary,
  // so the datapath only ever needs an unsigned compare.
  assign w_flip = {bus.signed_mode, {(W-1){1'b0}}};

  assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

  comparador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a  (w_a_chunk),
    .i_b  (w_b_chunk),
    .o_eq (w_chunk_eq),
    .o_gt (w_chunk_gt)
  );

  // The first differing chunk decides; lower chunks never override it.
  assign w_diff_next = r_diff | ~w_chunk_eq;
  assign w_gt_next   = r_diff ? r_gt_found : w_chunk_gt;
  assign w_end       = ((EARLY_EXIT != 0) && !w_chunk_eq) || (r_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_diff     <= 1'b0;
      r_gt_found <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res      <= RES_NONE;
      r_cycles   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a        <= bus.a ^ w_flip;
            r_b        <= bus.b ^ w_flip;
            r_idx      <= IW'(NCHUNK - 1);
            r_cnt      <= '0;
            r_diff     <= 1'b0;
            r_gt_found <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_cnt      <= r_cnt + 1'b1;
          r_diff     <= w_diff_next;
          r_gt_found <= w_gt_next;
          if (w_end) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_cycles <= r_cnt + 1'b1;
            r_res    <= !w_diff_next ? RES_EQ : (w_gt_next ? RES_GT : RES_LT);
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.eq     = |(r_res & RES_EQ);
  assign bus.lt     = |(r_res & RES_LT);
  assign bus.gt     = |(r_res & RES_GT);
  assign bus.cycles = r_cycles;

endmodule
